pes_fdiv: RTL
=============

# pes_fdiv

Iterative IEEE-754 single-precision divider, the inverse-operation companion to `pes_fmul` in the floating-point datapath. It accepts one operand pair per transaction over a valid/ready handshake and computes the quotient `c = a / b` with a radix-2 restoring mantissa divider, one quotient bit per cycle. The result is returned over a second valid/ready handshake with exception flags. Its normal-number, denormals-flushed format matches `pes_fmul`, so the two blocks interchange freely.

## Interface
- No parameters; widths are fixed at binary32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block idle and able to accept operands.
- `a` in 32: dividend, binary32.
- `b` in 32: divisor, binary32.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `c` out 32: quotient, binary32.
- `flags` out 3: `{ovf, unf, dz}`.

## Operation
- **States:** IDLE, NORM, DIV, DONE. `in_ready = (state == IDLE)`.
- **IDLE:** when `in_valid && in_ready`, register `a` and `b`, then go to NORM.
- **NORM:**
  - Zero detection: an operand is zero when its exponent field is 0 (denormals flush to zero).
  - Result sign is `sa ^ sb`.
  - Mantissas are `ma = {1, a[22:0]}` and `mb = {1, b[22:0]}`.
  - Exponent is `e = ea - eb + 127 - (ma < mb)`, computed as 10-bit signed.
  - Initial remainder is `r = (ma < mb) ? ma << 1 : ma`, 25 bits.
- **Special cases:** these are resolved in NORM, go directly to DONE, and skip DIV.
  - `b` zero: `c = {s, 8'hFF, 23'h0}`, `dz = 1`. This takes priority, so 0/0 also gives infinity.
  - `a` zero: `c = {s, 31'h0}`.
- **DIV:** 24 iterations, one per cycle.
  - Each iteration sets `q_bit = (r >= mb)`; if set, `r = r - mb`; then `r = r << 1`.
  - The quotient shifts in MSB first, and `q[23]` is always 1.
- **Final pack:** computed on exit from DIV.
  - If `e >= 255`: `c = {s, 8'hFF, 0}`, `ovf = 1`.
  - Else if `e <= 0`: `c = {s, 31'h0}`, `unf = 1`.
  - Else: `c = {s, e[7:0], q[22:0]}` (truncated).
- **DONE:** `out_valid = 1`. `c` and `flags` are held stable until `out_ready` is seen, then the block returns to IDLE. A new accept cannot overlap DONE.
- **Input exclusions:** NaN and infinity inputs (exponent 0xFF) are unsupported and are treated as normal numbers.
- **Reset:** `rst` aborts any state and returns to IDLE. On reset, `out_valid = 0`, `c = 0`, `flags = 0`, and `in_ready = 1` from the cycle after reset.

## Timing
- Accept is cycle 0, NORM is cycle 1, DIV occupies cycles 2–25, and `out_valid` rises in cycle 26. Normal latency is 26 cycles.
- Special cases: `out_valid` rises in cycle 2.
- Throughput is one operation per (latency + 1 + backpressure) cycles.
- `c` and `flags` change only on entry to DONE.
- `rst` asserted in any cycle takes priority over a handshake in that same cycle.
- Holding `out_ready` high in DONE completes the handshake in exactly one cycle.

## Configuration
- **`PES_FDIV_ROUND_EN` defined:**
  - DIV runs 25 iterations; the extra bit is the guard bit, and sticky = `(r != 0)`.
  - Rounding is round-to-nearest-even.
  - A mantissa carry-out increments `e`; if that gives `e == 255`, the result is infinity with `ovf = 1`.
  - Normal latency becomes 27 cycles.
- **Undefined:** 24 iterations, truncation, 26-cycle latency.
- Special-case latency is 2 cycles in both builds.

## Structure
- Shared package `pes_fp_pkg` holds:
  - `EXP_W = 8`, `MAN_W = 23`, `BIAS = 127`;
  - the state enum;
  - the `{ovf, unf, dz}` flags struct.
- One sub-module, `pes_fdiv_step`: a combinational single restoring iteration taking `(r, mb)` and producing `(r_next, q_bit)`, instantiated once. The top level holds the FSM, the iteration counter and the pack logic.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> `c = 0x40400000`, flags 0, `out_valid` exactly 26 cycles after accept (27 with rounding).
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA without `PES_FDIV_ROUND_EN`; 0x3EAAAAAB with it.
- 0xC1000000 / 0x3F000000 (−8/0.5) -> 0xC1800000. Also 0x00000000 / 0x40000000 -> 0x00000000 with flags 0 and latency 2.
- 0x40A00000 / 0x00000000 -> 0x7F800000, `dz = 1`, latency 2. Also 0x80000000 / 0x00000000 -> 0xFF800000, `dz = 1`.
- 0x7F000000 / 0x00800000 -> 0x7F800000, `ovf = 1`. Also 0x00800000 / 0x7F000000 -> 0x00000000, `unf = 1`.
- Backpressure and reset:
  - Hold `out_ready = 0` for 10 cycles in DONE -> `out_valid`, `c` and `flags` stable, `in_ready = 0`.
  - Assert `rst` at DIV cycle 10 -> next cycle `out_valid = 0`, `in_ready = 1`. A following 6/2 completes correctly.

Source files
------------

// File: rtl/pes_fp_pkg.sv
// Shared floating-point definitions for the binary32 datapath blocks.
// Optional feature macro: PES_FDIV_ROUND_EN (divider round-to-nearest-even).
package pes_fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Significand with hidden one, and remainder with one headroom bit
    localparam int SIG_W = MAN_W + 1;
    localparam int REM_W = SIG_W + 1;

`ifdef PES_FDIV_ROUND_EN
    // One extra quotient bit serves as the guard bit
    localparam int DIV_ITERS = SIG_W + 1;
`else
    localparam int DIV_ITERS = SIG_W;
`endif

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_DIV,
        ST_DONE
    } fdiv_state_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic dz;
    } fdiv_flags_t;

    // Denormals are flushed: a zero exponent field means the value is zero
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == '0;
    endfunction

endpackage

// File: rtl/pes_fdiv_step.sv
// One combinational restoring-division iteration: compare, conditionally
// subtract the divisor, then shift the remainder left by one.
module pes_fdiv_step
    import pes_fp_pkg::*;
(
    input  logic [REM_W-1:0] r,
    input  logic [SIG_W-1:0] mb,
    output logic [REM_W-1:0] r_next,
    output logic             q_bit
);

    logic [REM_W-1:0] mb_ext;
    logic [REM_W-1:0] r_sub;

    assign mb_ext = {1'b0, mb};
    assign q_bit  = (r >= mb_ext);
    assign r_sub  = q_bit ? (r - mb_ext) : r;
    // r_sub < mb < 2^24 here, so the shift never loses the top bit
    assign r_next = {r_sub[REM_W-2:0], 1'b0};

endmodule

// File: rtl/pes_fdiv.sv
// Iterative binary32 divider c = a / b, radix-2 restoring, one quotient bit
// per cycle, denormals flushed to zero. Results are truncated by default;
// defining PES_FDIV_ROUND_EN adds a guard iteration and round-to-nearest-even.
module pes_fdiv
    import pes_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c,
    output logic [2:0]  flags
);

    fdiv_state_t          state_reg, state_next;
    logic [31:0]          a_reg, a_next;
    logic [31:0]          b_reg, b_next;
    logic                 sign_reg, sign_next;
    logic signed [9:0]    exp_reg, exp_next;
    logic [SIG_W-1:0]     mb_reg, mb_next;
    logic [REM_W-1:0]     rem_reg, rem_next;
    logic [DIV_ITERS-1:0] q_reg, q_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [31:0]          c_reg, c_next;
    fdiv_flags_t          flags_reg, flags_next;

    // Operand decode used while in NORM
    logic [SIG_W-1:0]     ma_w, mb_w;
    logic                 a_zero, b_zero, ma_lt_mb, sign_w;
    logic signed [9:0]    exp_w;
    logic [REM_W-1:0]     rem_init;

    assign ma_w     = {1'b1, a_reg[MAN_W-1:0]};
    assign mb_w     = {1'b1, b_reg[MAN_W-1:0]};
    assign a_zero   = is_zero(a_reg);
    assign b_zero   = is_zero(b_reg);
    assign ma_lt_mb = (ma_w < mb_w);
    assign sign_w   = a_reg[31] ^ b_reg[31];
    // Pre-normalise: when ma < mb the quotient is below 1, so double the
    // dividend and take one off the exponent to keep q[MSB] = 1
    assign exp_w    = {2'b00, a_reg[30:23]} - {2'b00, b_reg[30:23]}
                    + 10'(BIAS) - {9'b0, ma_lt_mb};
    assign rem_init = ma_lt_mb ? {ma_w, 1'b0} : {1'b0, ma_w};

    // Single shared iteration stage
    logic [REM_W-1:0]     step_rem;
    logic                 step_q;
    logic [DIV_ITERS-1:0] q_shift;

    pes_fdiv_step u_step (
        .r      (rem_reg),
        .mb     (mb_reg),
        .r_next (step_rem),
        .q_bit  (step_q)
    );

    assign q_shift = {q_reg[DIV_ITERS-2:0], step_q};

    // Final exponent and mantissa, taken from the last iteration's outputs
    logic signed [9:0]    exp_fin;
    logic [MAN_W-1:0]     man_fin;

`ifdef PES_FDIV_ROUND_EN
    logic                 guard_bit, sticky_bit, round_up;
    logic [SIG_W:0]       sig_rnd;

    // Round to nearest even; a carry out of the significand bumps the exponent
    always_comb begin
        guard_bit  = q_shift[0];
        sticky_bit = |step_rem;
        round_up   = guard_bit & (sticky_bit | q_shift[1]);
        sig_rnd    = {1'b0, q_shift[DIV_ITERS-1:1]} + {{SIG_W{1'b0}}, round_up};
        man_fin    = sig_rnd[MAN_W-1:0];
        exp_fin    = exp_reg + {9'b0, sig_rnd[SIG_W]};
    end
`else
    assign man_fin = q_shift[MAN_W-1:0];
    assign exp_fin = exp_reg;
`endif

    logic [31:0]          pack_c;
    fdiv_flags_t          pack_flags;

    // Range check and pack into binary32
    always_comb begin
        pack_c     = {sign_reg, 31'h0};
        pack_flags = '0;
        if (exp_fin >= 10'sd255) begin
            pack_c         = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags.ovf = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            pack_flags.unf = 1'b1;
        end else begin
            pack_c = {sign_reg, exp_fin[EXP_W-1:0], man_fin};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sign_next  = sign_reg;
        exp_next   = exp_reg;
        mb_next    = mb_reg;
        rem_next   = rem_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        flags_next = flags_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    state_next = ST_NORM;
                end
            end
            ST_NORM: begin
                sign_next = sign_w;
                exp_next  = exp_w;
                mb_next   = mb_w;
                rem_next  = rem_init;
                q_next    = '0;
                cnt_next  = '0;
                if (b_zero) begin
                    // Divide by zero wins, so 0/0 also yields infinity
                    c_next        = {sign_w, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_next    = '0;
                    flags_next.dz = 1'b1;
                    state_next    = ST_DONE;
                end else if (a_zero) begin
                    c_next     = {sign_w, 31'h0};
                    flags_next = '0;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_next = step_rem;
                q_next   = q_shift;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(DIV_ITERS - 1)) begin
                    c_next     = pack_c;
                    flags_next = pack_flags;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            mb_reg    <= '0;
            rem_reg   <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            c_reg     <= '0;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sign_reg  <= sign_next;
            exp_reg   <= exp_next;
            mb_reg    <= mb_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
            flags_reg <= flags_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign c         = c_reg;
    assign flags     = flags_reg;

endmodule
